// File: rtl/circ_buf_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : circ_buf_mp_pkg
//  Description : Shared entry typedefs, default geometry and width helpers
//                for the multi-port circular issue queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package circ_buf_mp_pkg;

    localparam int CB_DEPTH       = 16;
    localparam int CB_INS_COUNT   = 4;
    localparam int CB_EXT_COUNT   = 4;
    localparam int CB_PARTIAL_INS = 1;

    typedef struct packed {
        logic [5:0] rob_id;
        logic [6:0] pdst;
        logic [6:0] psrc1;
        logic [6:0] psrc2;
        logic [3:0] fu_op;
        logic       rdy;
    } iq_entry_t;

    // Width of a true count 0..n
    function automatic int cb_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of a pointer into an n-deep ring
    function automatic int cb_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/circ_buf_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : circ_buf_ptr_ctrl
//  Description : Head/tail/occupancy bookkeeping for circ_buf_mp: lane
//                clipping, insert acceptance, extract and squash amounts.
//  Revision    : 1.0 - initial release
// ============================================================================
module circ_buf_ptr_ctrl
    import circ_buf_mp_pkg::*;
#(
    parameter int DEPTH       = CB_DEPTH,
    parameter int INS_COUNT   = CB_INS_COUNT,
    parameter int EXT_COUNT   = CB_EXT_COUNT,
    parameter int PARTIAL_INS = CB_PARTIAL_INS,
    localparam int DLW  = cb_ptr_w(DEPTH),
    localparam int INSW = cb_cnt_w(INS_COUNT),
    localparam int EXTW = cb_cnt_w(EXT_COUNT),
    localparam int CW   = DLW + 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            ins_valid_i,
    input  logic [INSW-1:0] ins_count_i,
    input  logic [EXTW-1:0] ext_count_i,
    input  logic            flush_i,
    input  logic            squash_valid_i,
    input  logic [CW-1:0]   squash_count_i,
    output logic [DLW-1:0]  head_o,
    output logic [DLW-1:0]  tail_o,
    output logic [INSW-1:0] ins_accepted_o,
    output logic [EXTW-1:0] ext_taken_o,
    output logic [CW-1:0]   sq_o,
    output logic [CW-1:0]   used_count_o,
    output logic [CW-1:0]   used_next_o,
    output logic [CW-1:0]   free_count_o,
    output logic            empty_o,
    output logic            full_o
);

    // One spare bit above a count so intermediate sums/differences never wrap
    localparam int AW = DLW + 2;

    logic [DLW-1:0] head_q, head_d;
    logic [DLW-1:0] tail_q, tail_d;
    logic [CW-1:0]  used_q, used_d;

    logic [AW-1:0] used_w;
    logic [AW-1:0] free_w;
    logic [AW-1:0] ins_clip;
    logic [AW-1:0] ext_clip;
    logic [AW-1:0] sq_req;
    logic [AW-1:0] ext_taken;
    logic [AW-1:0] sq_amt;
    logic [AW-1:0] ins_acc;
    logic [AW-1:0] used_nx;

    always_comb begin
        used_w    = AW'(used_q);
        free_w    = AW'(DEPTH) - used_w;
        ins_clip  = (AW'(ins_count_i) > AW'(INS_COUNT)) ? AW'(INS_COUNT) : AW'(ins_count_i);
        ext_clip  = (AW'(ext_count_i) > AW'(EXT_COUNT)) ? AW'(EXT_COUNT) : AW'(ext_count_i);
        sq_req    = AW'(squash_count_i);
        ext_taken = '0;
        sq_amt    = '0;
        ins_acc   = '0;
        if (!flush_i) begin
            ext_taken = (ext_clip < used_w) ? ext_clip : used_w;
            if (squash_valid_i) begin
                // Squash only reaches entries that survive this cycle's extract
                sq_amt = (sq_req < (used_w - ext_taken)) ? sq_req : (used_w - ext_taken);
            end else if (ins_valid_i) begin
                if (ins_clip <= free_w) begin
                    ins_acc = ins_clip;
                end else if (PARTIAL_INS != 0) begin
                    ins_acc = free_w;
                end
            end
        end
    end

    always_comb begin
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            used_nx = '0;
        end else begin
            head_d  = head_q + DLW'(ext_taken);
            tail_d  = tail_q + DLW'(ins_acc) - DLW'(sq_amt);
            used_nx = used_w + ins_acc - ext_taken - sq_amt;
        end
        used_d = CW'(used_nx);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            used_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            used_q <= used_d;
        end
    end

    assign head_o         = head_q;
    assign tail_o         = tail_q;
    assign ins_accepted_o = INSW'(ins_acc);
    assign ext_taken_o    = EXTW'(ext_taken);
    assign sq_o           = CW'(sq_amt);
    assign used_count_o   = used_q;
    assign used_next_o    = used_d;
    assign free_count_o   = CW'(free_w);
    assign empty_o        = (used_q == '0);
    assign full_o         = (free_w < AW'(INS_COUNT));

endmodule
`default_nettype wire

// File: rtl/circ_buf_mp.sv
`default_nettype none
// ============================================================================
//  Module      : circ_buf_mp
//  Description : Multi-port circular queue between dispatch and issue with
//                partial insert, multi-extract, flush and tail squash.
//                Define CIRCBUF_HWM_EN to enable the max_used high-water mark.
//  Revision    : 1.0 - initial release
// ============================================================================
module circ_buf_mp
    import circ_buf_mp_pkg::*;
#(
    parameter type T          = iq_entry_t,
    parameter int DEPTH       = CB_DEPTH,
    parameter int INS_COUNT   = CB_INS_COUNT,
    parameter int EXT_COUNT   = CB_EXT_COUNT,
    parameter int PARTIAL_INS = CB_PARTIAL_INS,
    localparam int DLW  = cb_ptr_w(DEPTH),
    localparam int INSW = cb_cnt_w(INS_COUNT),
    localparam int EXTW = cb_cnt_w(EXT_COUNT),
    localparam int CW   = DLW + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ins_valid_i,
    input  logic [INSW-1:0]      ins_count_i,
    input  T                     ins_elements_i [INS_COUNT],
    output logic [INSW-1:0]      ins_accepted_o,
    input  logic [EXTW-1:0]      ext_count_i,
    output logic [EXT_COUNT-1:0] out_valid_o,
    output T                     out_elements_o [EXT_COUNT],
    input  logic                 flush_i,
    input  logic                 squash_valid_i,
    input  logic [CW-1:0]        squash_count_i,
    output logic [CW-1:0]        used_count_o,
    output logic [CW-1:0]        free_count_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [CW-1:0]        max_used_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < INS_COUNT || DEPTH < EXT_COUNT) begin : g_bad_cfg
        $error("circ_buf_mp: DEPTH must be a power of two >= 2, INS_COUNT and EXT_COUNT");
    end

    logic [DLW-1:0]  head;
    logic [DLW-1:0]  tail;
    logic [INSW-1:0] ins_accepted;
    logic [EXTW-1:0] ext_taken;
    logic [CW-1:0]   sq;
    logic [CW-1:0]   used_next;

    T                 buf_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    circ_buf_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .INS_COUNT   (INS_COUNT),
        .EXT_COUNT   (EXT_COUNT),
        .PARTIAL_INS (PARTIAL_INS)
    ) u_ptr_ctrl (
        .clock          (clock),
        .reset_n        (reset_n),
        .ins_valid_i    (ins_valid_i),
        .ins_count_i    (ins_count_i),
        .ext_count_i    (ext_count_i),
        .flush_i        (flush_i),
        .squash_valid_i (squash_valid_i),
        .squash_count_i (squash_count_i),
        .head_o         (head),
        .tail_o         (tail),
        .ins_accepted_o (ins_accepted),
        .ext_taken_o    (ext_taken),
        .sq_o           (sq),
        .used_count_o   (used_count_o),
        .used_next_o    (used_next),
        .free_count_o   (free_count_o),
        .empty_o        (empty_o),
        .full_o         (full_o)
    );

    assign ins_accepted_o = ins_accepted;

    // Payload needs no reset: it is only observed through the valid bits
    always_ff @(posedge clock) begin
        for (int l = 0; l < INS_COUNT; l++) begin
            if (INSW'(l) < ins_accepted) begin
                buf_q[tail + DLW'(l)] <= ins_elements_i[l];
            end
        end
    end

    // Extract, squash and insert touch disjoint slots, so order is immaterial
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < EXT_COUNT; i++) begin
                if (EXTW'(i) < ext_taken) begin
                    valid_d[head + DLW'(i)] = 1'b0;
                end
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (CW'(j) < sq) begin
                    valid_d[tail - DLW'(j) - DLW'(1)] = 1'b0;
                end
            end
            for (int l = 0; l < INS_COUNT; l++) begin
                if (INSW'(l) < ins_accepted) begin
                    valid_d[tail + DLW'(l)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < EXT_COUNT; i++) begin
            out_elements_o[i] = buf_q[head + DLW'(i)];
            out_valid_o[i]    = valid_q[head + DLW'(i)];
        end
    end

`ifdef CIRCBUF_HWM_EN
    logic [CW-1:0] max_used_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            max_used_q <= '0;
        end else if (used_next > max_used_q) begin
            max_used_q <= used_next;
        end
    end

    assign max_used_o = max_used_q;
`else
    logic unused_hwm;
    assign unused_hwm = ^used_next;
    assign max_used_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_circ_buf_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circ_buf_mp
//  Description : Self-checking bench for circ_buf_mp (queue reference model
//                plus directed literal expectations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_circ_buf_mp;
    import circ_buf_mp_pkg::*;

    localparam int DEPTH = 16;
    localparam int NINS  = 4;
    localparam int NEXT  = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ins_valid = 1'b0;
    logic [2:0] ins_count = '0;
    iq_entry_t  ins_el [NINS];
    logic [2:0] ext_count = '0;
    logic       flush = 1'b0;
    logic       squash_valid = 1'b0;
    logic [4:0] squash_count = '0;

    logic [2:0] acc_a, acc_b;
    logic [3:0] oval_a, oval_b;
    iq_entry_t  oel_a [NEXT];
    iq_entry_t  oel_b [NEXT];
    logic [4:0] used_a, free_a, max_a, used_b, free_b, max_b;
    logic       empty_a, full_a, empty_b, full_b;

    int n_chk  = 0;
    int n_fail = 0;

    iq_entry_t  mq [$];
    int         m_max = 0;
    logic [31:0] seq = 32'h100;
    logic [31:0] last_base;
    int          last_acc, last_acc_b;

    always #5 clock = ~clock;

    circ_buf_mp #(.T(iq_entry_t), .DEPTH(DEPTH), .INS_COUNT(NINS), .EXT_COUNT(NEXT), .PARTIAL_INS(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .ins_valid_i(ins_valid), .ins_count_i(ins_count),
        .ins_elements_i(ins_el), .ins_accepted_o(acc_a), .ext_count_i(ext_count),
        .out_valid_o(oval_a), .out_elements_o(oel_a), .flush_i(flush),
        .squash_valid_i(squash_valid), .squash_count_i(squash_count),
        .used_count_o(used_a), .free_count_o(free_a), .empty_o(empty_a), .full_o(full_a),
        .max_used_o(max_a)
    );

    circ_buf_mp #(.T(iq_entry_t), .DEPTH(DEPTH), .INS_COUNT(NINS), .EXT_COUNT(NEXT), .PARTIAL_INS(0)) u_dut_aon (
        .clock(clock), .reset_n(reset_n), .ins_valid_i(ins_valid), .ins_count_i(ins_count),
        .ins_elements_i(ins_el), .ins_accepted_o(acc_b), .ext_count_i(ext_count),
        .out_valid_o(oval_b), .out_elements_o(oel_b), .flush_i(flush),
        .squash_valid_i(squash_valid), .squash_count_i(squash_count),
        .used_count_o(used_b), .free_count_o(free_b), .empty_o(empty_b), .full_o(full_b),
        .max_used_o(max_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lanes the queue takes this cycle, judged on occupancy before the edge
    function automatic int m_accept();
        int want, room;
        if (!ins_valid || flush || squash_valid) return 0;
        want = (int'(ins_count) > NINS) ? NINS : int'(ins_count);
        room = DEPTH - mq.size();
        if (want <= room) return want;
        return room;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_max = 0;
        end else begin
            int acc, ec, sq;
            acc = m_accept();
            if (flush) begin
                mq.delete();
            end else begin
                ec = (int'(ext_count) > NEXT) ? NEXT : int'(ext_count);
                for (int k = 0; k < ec && mq.size() > 0; k++) void'(mq.pop_front());
                if (squash_valid) begin
                    sq = int'(squash_count);
                    for (int k = 0; k < sq && mq.size() > 0; k++) void'(mq.pop_back());
                end
                for (int k = 0; k < acc; k++) mq.push_back(ins_el[k]);
            end
            if (mq.size() > m_max) m_max = mq.size();
        end
    end

    always @(negedge clock) begin
        logic [3:0] ev;
        int exp_max;
`ifdef CIRCBUF_HWM_EN
        exp_max = m_max;
`else
        exp_max = 0;
`endif
        ev = '0;
        for (int i = 0; i < NEXT; i++) ev[i] = (i < mq.size());
        chk("m_used",  32'(used_a),  32'(mq.size()));
        chk("m_free",  32'(free_a),  32'(DEPTH - mq.size()));
        chk("m_empty", 32'(empty_a), 32'(mq.size() == 0));
        chk("m_full",  32'(full_a),  32'((DEPTH - mq.size()) < NINS));
        chk("m_max",   32'(max_a),   32'(exp_max));
        chk("m_acc",   32'(acc_a),   32'(m_accept()));
        chk("m_oval",  32'(oval_a),  32'(ev));
        for (int i = 0; i < NEXT; i++) begin
            if (i < mq.size()) chk("m_elem", 32'(oel_a[i]), 32'(mq[i]));
        end
    end

    task automatic cyc(input int iv, input int ic, input int ec, input int fl, input int sv, input int sc);
        ins_valid    = iv[0];
        ins_count    = 3'(ic);
        ext_count    = 3'(ec);
        flush        = fl[0];
        squash_valid = sv[0];
        squash_count = 5'(sc);
        last_base    = seq;
        for (int l = 0; l < NINS; l++) begin
            ins_el[l] = seq;
            seq       = seq + 32'd1;
        end
        #1;
        last_acc   = int'(acc_a);
        last_acc_b = int'(acc_b);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_hwm;
        for (int l = 0; l < NINS; l++) ins_el[l] = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // reset state
        chk("rst_used",  32'(used_a),  32'd0);
        chk("rst_free",  32'(free_a),  32'd16);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_full",  32'(full_a),  32'd0);
        chk("rst_oval",  32'(oval_a),  32'd0);
        chk("rst_acc",   32'(acc_a),   32'd0);

        // fill in chunks of four
        for (int k = 0; k < 4; k++) begin
            cyc(1, 4, 0, 0, 0, 0);
            chk("fill_acc",  32'(last_acc), 32'd4);
            chk("fill_used", 32'(used_a),   32'(4 * (k + 1)));
            chk("fill_full", 32'(full_a),   32'(k == 3));
        end
        cyc(1, 4, 0, 0, 0, 0);
        chk("full_acc", 32'(last_acc), 32'd0);

        // partial vs all-or-none at used=14
        cyc(0, 0, 2, 0, 0, 0);
        chk("u14_used", 32'(used_a), 32'd14);
        cyc(1, 4, 0, 0, 0, 0);
        chk("part_acc",  32'(last_acc),   32'd2);
        chk("part_used", 32'(used_a),     32'd16);
        chk("aon_acc",   32'(last_acc_b), 32'd0);
        chk("aon_used",  32'(used_b),     32'd14);
        cyc(0, 0, 0, 1, 0, 0);
        chk("resync_b", 32'(used_b), 32'd0);

        // move head to 14, then wrap
        for (int k = 0; k < 3; k++) cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, 4, 0, 0, 0);
        cyc(0, 0, 2, 0, 0, 0);
        chk("h14_empty", 32'(empty_a), 32'd1);
        cyc(1, 4, 0, 0, 0, 0);
        chk("wrap_e0",   32'(oel_a[0]), last_base);
        chk("wrap_e1",   32'(oel_a[1]), last_base + 32'd1);
        chk("wrap_e3",   32'(oel_a[3]), last_base + 32'd3);
        chk("wrap_oval", 32'(oval_a),   32'hF);
        cyc(0, 0, 3, 0, 0, 0);
        chk("wrap_used", 32'(used_a),   32'd1);
        chk("wrap_head", 32'(oel_a[0]), last_base - 32'd1);
        chk("wrap_ov1",  32'(oval_a),   32'h1);

        // over-extract
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 0, 4, 0, 0, 0);
        chk("oext_used",  32'(used_a),  32'd0);
        chk("oext_empty", 32'(empty_a), 32'd1);
        chk("oext_oval",  32'(oval_a),  32'd0);

        // squash with concurrent extract and blocked insert
        cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 2, 0, 0, 0, 0);
        chk("sq_pre", 32'(used_a), 32'd10);
        cyc(1, 3, 2, 0, 1, 5);
        chk("sq_acc",  32'(last_acc), 32'd0);
        chk("sq_used", 32'(used_a),   32'd3);
        cyc(1, 7, 0, 0, 0, 0);
        chk("clip_acc",  32'(last_acc), 32'd4);
        chk("clip_used", 32'(used_a),   32'd7);
        cyc(0, 0, 7, 0, 1, 16);
        chk("sqall_used", 32'(used_a), 32'd0);

        // flush beats everything
        cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("fl_pre", 32'(used_a), 32'd9);
        cyc(1, 4, 2, 1, 1, 3);
`ifdef CIRCBUF_HWM_EN
        exp_hwm = 16;
`else
        exp_hwm = 0;
`endif
        chk("fl_acc",   32'(last_acc), 32'd0);
        chk("fl_used",  32'(used_a),   32'd0);
        chk("fl_empty", 32'(empty_a),  32'd1);
        chk("fl_hwm",   32'(max_a),    32'(exp_hwm));

        // asynchronous reset mid-stream
        cyc(1, 4, 0, 0, 0, 0);
        cyc(1, 4, 0, 0, 0, 0);
        ins_valid = 1'b0;
        ins_count = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_used",  32'(used_a),  32'd0);
        chk("arst_free",  32'(free_a),  32'd16);
        chk("arst_empty", 32'(empty_a), 32'd1);
        chk("arst_oval",  32'(oval_a),  32'd0);
        chk("arst_max",   32'(max_a),   32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        cyc(1, 3, 0, 0, 0, 0);
        chk("post_used", 32'(used_a), 32'd3);
        chk("post_e0",   32'(oel_a[0]), last_base);
        cyc(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
